sha256_transform_core: RTL and testbench

//  One SHA-256 compression function (64 rounds) on a 512-bit block, chained from a caller-supplied 256-bit state.

---
 rtl/sha256_transform_core.sv | 90 +++++++++
 tb/tb_sha256_transform_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_transform_core.sv
// SHA-256 compression core: 64/LOOP round stages, each reused LOOP times via feedback/cnt.
// Digest = last-stage a..h + rx_state, registered; valid 64 edges after a block is sampled.
module sha256_transform_core #(
    parameter int LOOP = 1
) (
    input  logic         hash_clk,
    input  logic         reset,
    input  logic         feedback,
    input  logic [5:0]   cnt,
    input  logic [255:0] rx_state,
    input  logic [511:0] rx_input,
    output logic [255:0] tx_hash
);

    localparam int NS = 64 / LOOP;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One round on state a..h ([31:0]=a) and a 16-word window holding W[r..r+15] ([31:0]=W[r]).
    // Returns {window shifted by one with W[r+16] appended, next a..h}.
    function automatic logic [767:0] sha_round(input logic [255:0] st, input logic [511:0] w,
                                               input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] t1, t2, s0, s1, w_new;
        a = st[31:0];    b = st[63:32];   c = st[95:64];   d = st[127:96];
        e = st[159:128]; f = st[191:160]; g = st[223:192]; h = st[255:224];
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w[31:0];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        s0 = rotr(w[63:32], 7) ^ rotr(w[63:32], 18) ^ (w[63:32] >> 3);
        s1 = rotr(w[479:448], 17) ^ rotr(w[479:448], 19) ^ (w[479:448] >> 10);
        w_new = s1 + w[319:288] + s0 + w[31:0];
        return {w_new, w[511:32], g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    logic [255:0] st_q [NS];
    logic [511:0] w_q  [NS];

    for (genvar s = 0; s < NS; s++) begin : g_stage
        localparam logic [5:0] RBASE = 6'(s * LOOP);
        logic [255:0] st_src;
        logic [511:0] w_src;
        logic [5:0]   rnd;

        assign rnd = RBASE + cnt;

        if (s == 0) begin : g_first
            always_comb begin
                st_src = feedback ? st_q[0] : rx_state;
                w_src  = feedback ? w_q[0]  : rx_input;
            end
        end else begin : g_next
            always_comb begin
                st_src = feedback ? st_q[s] : st_q[s-1];
                w_src  = feedback ? w_q[s]  : w_q[s-1];
            end
        end

        always_ff @(posedge hash_clk) begin
            if (reset) begin
                st_q[s] <= '0;
                w_q[s]  <= '0;
            end else begin
                {w_q[s], st_q[s]} <= sha_round(st_src, w_src, K[rnd]);
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            tx_hash <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                tx_hash[i*32 +: 32] <= st_q[NS-1][i*32 +: 32] + rx_state[i*32 +: 32];
        end
    end

endmodule

// File: tb/tb_sha256_transform_core.sv
// Bench for sha256_transform_core: LOOP=1 and LOOP=32 instances against a plain SHA-256 compression model.
module tb_sha256_transform_core;

    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           due;
        logic [255:0] dig;
        bit           has_lo;
        bit           has_hi;
        logic [31:0]  lo;
        logic [31:0]  hi;
    } exp_t;

    logic         hash_clk = 1'b0;
    logic         reset = 1'b1;
    logic         feedback1 = 1'b0, feedback32 = 1'b0;
    logic [5:0]   cnt1 = '0, cnt32 = '0;
    logic [255:0] rx_state1 = IV, rx_state32 = IV;
    logic [511:0] rx_input1 = '0, rx_input32 = '0;
    logic [255:0] tx_hash1, tx_hash32;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q32[$];

    sha256_transform_core #(.LOOP(1)) dut1 (
        .hash_clk(hash_clk), .reset(reset), .feedback(feedback1), .cnt(cnt1),
        .rx_state(rx_state1), .rx_input(rx_input1), .tx_hash(tx_hash1));

    sha256_transform_core #(.LOOP(32)) dut32 (
        .hash_clk(hash_clk), .reset(reset), .feedback(feedback32), .cnt(cnt32),
        .rx_state(rx_state32), .rx_input(rx_input32), .tx_hash(tx_hash32));

    always #5 hash_clk = ~hash_clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = st[i*32 +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i] + st[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Single compare process: after every edge, check whichever expected digests fall due now.
    always begin
        @(posedge hash_clk);
        cyc++;
        #1;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            if (q1[0].due < cyc) check("loop1_missed", 256'(q1[0].due), 256'(cyc));
            else begin
                check("loop1_digest", tx_hash1, q1[0].dig);
                if (q1[0].has_lo) check("loop1_lit_h0", 256'(tx_hash1[31:0]), 256'(q1[0].lo));
                if (q1[0].has_hi) check("loop1_lit_h7", 256'(tx_hash1[255:224]), 256'(q1[0].hi));
            end
            void'(q1.pop_front());
        end
        while (q32.size() > 0 && q32[0].due <= cyc) begin
            if (q32[0].due < cyc) check("loop32_missed", 256'(q32[0].due), 256'(cyc));
            else begin
                check("loop32_digest", tx_hash32, q32[0].dig);
                if (q32[0].has_lo) check("loop32_lit_h0", 256'(tx_hash32[31:0]), 256'(q32[0].lo));
                if (q32[0].has_hi) check("loop32_lit_h7", 256'(tx_hash32[255:224]), 256'(q32[0].hi));
            end
            void'(q32.pop_front());
        end
    end

    task automatic make_exp(output exp_t e, input logic [255:0] st, input logic [511:0] blk,
                            input bit hl, input logic [31:0] lo, input bit hh, input logic [31:0] hi);
        e.due = cyc + 65;
        e.dig = compress(st, blk);
        e.has_lo = hl; e.lo = lo; e.has_hi = hh; e.hi = hi;
    endtask

    // LOOP=1 instance: one block per call, sampled at the next rising edge.
    task automatic send1(input logic [255:0] st, input logic [511:0] blk,
                         input bit hl, input logic [31:0] lo, input bit hh, input logic [31:0] hi);
        exp_t e;
        @(negedge hash_clk);
        rx_state1 = st;
        rx_input1 = blk;
        make_exp(e, st, blk, hl, lo, hh, hi);
        q1.push_back(e);
    endtask

    task automatic idle1();
        @(negedge hash_clk);
        rx_input1 = rand512();
    endtask

    task automatic drain1(input string name);
        int n = 0;
        while (q1.size() > 0 && n < 200) begin
            @(negedge hash_clk);
            n++;
        end
        if (q1.size() > 0) begin
            check(name, 256'(q1.size()), 256'(0));
            q1.delete();
        end
    endtask

    logic [511:0] blk_abc, blk_empty, blk_chain, b;
    logic [255:0] dig_abc, st;
    logic [255:0] stale [10];
    int           hits;

    initial begin
        blk_abc = '0;   blk_abc[31:0] = 32'h61626380; blk_abc[511:480] = 32'h00000018;
        blk_empty = '0; blk_empty[31:0] = 32'h80000000;
        dig_abc = compress(IV, blk_abc);
        blk_chain = '0; blk_chain[255:0] = dig_abc;
        blk_chain[287:256] = 32'h80000000; blk_chain[511:480] = 32'h00000100;

        // Pin the model against published SHA-256 values.
        check("model_abc_h0", 256'(dig_abc[31:0]), 256'(32'hba7816bf));
        st = compress(IV, blk_empty);
        check("model_empty_h7", 256'(st[255:224]), 256'(32'h7852b855));
        st = compress(IV, blk_chain);
        check("model_dsha_h0", 256'(st[31:0]), 256'(32'h4f8b42c2));

        repeat (3) @(negedge hash_clk);
        check("reset_loop1", tx_hash1, '0);
        check("reset_loop32", tx_hash32, '0);
        reset = 1'b0;

        // Known vectors back to back, then the double-hash chain block.
        send1(IV, blk_abc,   1, 32'hba7816bf, 1, 32'hf20015ad);
        send1(IV, blk_empty, 1, 32'he3b0c442, 1, 32'h7852b855);
        send1(IV, blk_chain, 1, 32'h4f8b42c2, 0, 32'h0);
        drain1("drain_known");

        // Random chaining states, random blocks with sporadic gaps.
        for (int bt = 0; bt < 3; bt++) begin
            st = rand256();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge hash_clk);
                    rx_state1 = st;
                    rx_input1 = rand512();
                end
                send1(st, rand512(), 0, 32'h0, 0, 32'h0);
            end
            drain1("drain_random");
        end

        // Reset mid-pipeline: in-flight blocks must vanish.
        for (int i = 0; i < 10; i++) begin
            b = rand512();
            stale[i] = compress(IV, b);
            send1(IV, b, 0, 32'h0, 0, 32'h0);
        end
        repeat (20) idle1();
        @(negedge hash_clk);
        reset = 1'b1;
        @(negedge hash_clk);
        check("reset_mid_loop1", tx_hash1, '0);
        q1.delete();
        reset = 1'b0;
        rx_input1 = blk_abc;
        begin
            exp_t e;
            make_exp(e, IV, blk_abc, 1, 32'hba7816bf, 1, 32'hf20015ad);
            q1.push_back(e);
        end
        hits = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge hash_clk);
            rx_input1 = rand512();
            for (int i = 0; i < 10; i++) if (tx_hash1 === stale[i]) hits++;
        end
        check("stale_digest_seen", 256'(hits), 256'(0));
        drain1("drain_after_reset");

        // LOOP=32: blocks every 32 cycles, cnt 0..31 with feedback on all but cnt 0.
        for (int k = 0; k < 300 && (k < 96 || q32.size() > 0); k++) begin
            @(negedge hash_clk);
            cnt32 = 6'(k % 32);
            feedback32 = (k % 32) != 0;
            if (k % 32 == 0 && k < 96) begin
                exp_t e;
                b = (k == 0) ? blk_abc : (k == 32) ? blk_empty : rand512();
                rx_input32 = b;
                if (k == 0)       make_exp(e, IV, b, 1, 32'hba7816bf, 1, 32'hf20015ad);
                else if (k == 32) make_exp(e, IV, b, 1, 32'he3b0c442, 1, 32'h7852b855);
                else              make_exp(e, IV, b, 0, 32'h0, 0, 32'h0);
                q32.push_back(e);
            end
        end
        if (q32.size() > 0) check("drain_loop32", 256'(q32.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
